// File: rtl/object_state_regs.sv
`default_nettype none
// ============================================================================
//  Module      : object_state_regs
//  Description : Double-buffered geometry store for one object. Host writes a
//                shadow bank; frame_start commits shadow -> active atomically.
//                Optional macro OBJ_AUTO_ROTATE_EN advances and wraps the
//                angles by ROT_STEP_* on every commit.
//  Revision    : 1.0 - initial release
// ============================================================================
module object_state_regs #(
    parameter logic [15:0] ROT_STEP_X = 16'h0024,
    parameter logic [15:0] ROT_STEP_Y = 16'h0012,
    parameter logic [15:0] ROT_STEP_Z = 16'h0000,
    parameter logic [15:0] PI_Q13     = 16'h6488
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [15:0] wr_data,
    output logic        wr_err,
    input  logic [4:0]  rd_addr,
    output logic [15:0] rd_data,
    input  logic        frame_start,
    output logic        commit_done,
    output logic [15:0] Xc,
    output logic [15:0] Yc,
    output logic [15:0] Zc,
    output logic [15:0] vtx1_X,
    output logic [15:0] vtx1_Y,
    output logic [15:0] vtx1_Z,
    output logic [15:0] vtx2_X,
    output logic [15:0] vtx2_Y,
    output logic [15:0] vtx2_Z,
    output logic [15:0] vtx3_X,
    output logic [15:0] vtx3_Y,
    output logic [15:0] vtx3_Z,
    output logic [15:0] vtx4_X,
    output logic [15:0] vtx4_Y,
    output logic [15:0] vtx4_Z,
    output logic [15:0] angleX,
    output logic [15:0] angleY,
    output logic [15:0] angleZ
);

    localparam logic [4:0] c_num_words = 5'd18;

    function automatic logic [15:0] f_reset_word(input int idx);
        case (idx)
            2:       f_reset_word = 16'h0640;
            4:       f_reset_word = 16'hff3c;
            6:       f_reset_word = 16'hff60;
            7:       f_reset_word = 16'h0041;
            8:       f_reset_word = 16'h005c;
            9:       f_reset_word = 16'h00a0;
            10:      f_reset_word = 16'h0041;
            11:      f_reset_word = 16'h005c;
            13:      f_reset_word = 16'h0041;
            14:      f_reset_word = 16'hff47;
            default: f_reset_word = 16'h0000;
        endcase
    endfunction

    logic [15:0] r_shadow      [0:17];
    logic [15:0] r_active      [0:17];
    logic [15:0] w_shadow_next [0:17];
    logic [15:0] w_commit_word [0:17];
    logic [15:0] r_rd_data;
    logic        r_wr_err;
    logic        r_commit_done;
    logic        w_wr_valid;

    assign w_wr_valid = wr_en && (wr_addr < c_num_words);

`ifdef OBJ_AUTO_ROTATE_EN
    localparam logic signed [16:0] c_pi     = {1'b0, PI_Q13};
    localparam logic signed [16:0] c_two_pi = {PI_Q13, 1'b0};

    logic [15:0] w_rot [0:2];

    // Sum is formed at 17 bits so the wrap compare sees the true value.
    for (genvar a = 0; a < 3; a++) begin : g_rot
        logic        [15:0] w_step;
        logic signed [16:0] w_sum;
        logic signed [16:0] w_wrapped;

        assign w_step = (a == 0) ? ROT_STEP_X : (a == 1) ? ROT_STEP_Y : ROT_STEP_Z;
        assign w_sum  = $signed({r_shadow[15+a][15], r_shadow[15+a]}) +
                        $signed({w_step[15], w_step});

        always_comb begin
            if (w_sum >= c_pi) begin
                w_wrapped = w_sum - c_two_pi;
            end else if (w_sum < -c_pi) begin
                w_wrapped = w_sum + c_two_pi;
            end else begin
                w_wrapped = w_sum;
            end
        end

        assign w_rot[a] = w_wrapped[15:0];
    end
`endif

    always_comb begin
        for (int i = 0; i < 18; i++) begin
            w_shadow_next[i] = r_shadow[i];
            w_commit_word[i] = r_shadow[i];
        end
`ifdef OBJ_AUTO_ROTATE_EN
        for (int a = 0; a < 3; a++) begin
            w_commit_word[15+a] = w_rot[a];
            if (frame_start) begin
                w_shadow_next[15+a] = w_rot[a];
            end
        end
`endif
        // Host write is applied last so it wins over the rotation update in shadow.
        if (w_wr_valid) begin
            w_shadow_next[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 18; i++) begin
                r_shadow[i] <= f_reset_word(i);
                r_active[i] <= f_reset_word(i);
            end
            r_rd_data     <= 16'h0000;
            r_wr_err      <= 1'b0;
            r_commit_done <= 1'b0;
        end else begin
            for (int i = 0; i < 18; i++) begin
                r_shadow[i] <= w_shadow_next[i];
                if (frame_start) begin
                    r_active[i] <= w_commit_word[i];
                end
            end
            r_rd_data     <= (rd_addr < c_num_words) ? w_shadow_next[rd_addr] : 16'h0000;
            r_wr_err      <= wr_en && !w_wr_valid;
            r_commit_done <= frame_start;
        end
    end

    assign rd_data     = r_rd_data;
    assign wr_err      = r_wr_err;
    assign commit_done = r_commit_done;

    assign Xc     = r_active[0];
    assign Yc     = r_active[1];
    assign Zc     = r_active[2];
    assign vtx1_X = r_active[3];
    assign vtx1_Y = r_active[4];
    assign vtx1_Z = r_active[5];
    assign vtx2_X = r_active[6];
    assign vtx2_Y = r_active[7];
    assign vtx2_Z = r_active[8];
    assign vtx3_X = r_active[9];
    assign vtx3_Y = r_active[10];
    assign vtx3_Z = r_active[11];
    assign vtx4_X = r_active[12];
    assign vtx4_Y = r_active[13];
    assign vtx4_Z = r_active[14];
    assign angleX = r_active[15];
    assign angleY = r_active[16];
    assign angleZ = r_active[17];

endmodule
`default_nettype wire

// File: tb/tb_object_state_regs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_object_state_regs
//  Description : Scoreboard bench for object_state_regs (shadow/active banks,
//                readback, invalid writes, commit collisions, reset, rotation).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_object_state_regs;

    logic        clk = 1'b0;
    logic        rst, wr_en, frame_start;
    logic [4:0]  wr_addr, rd_addr;
    logic [15:0] wr_data;
    logic        wr_err, commit_done;
    logic [15:0] rd_data;
    logic [15:0] Xc, Yc, Zc;
    logic [15:0] vtx1_X, vtx1_Y, vtx1_Z, vtx2_X, vtx2_Y, vtx2_Z;
    logic [15:0] vtx3_X, vtx3_Y, vtx3_Z, vtx4_X, vtx4_Y, vtx4_Z;
    logic [15:0] angleX, angleY, angleZ;

    object_state_regs dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(wr_err), .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_start(frame_start), .commit_done(commit_done),
        .Xc(Xc), .Yc(Yc), .Zc(Zc),
        .vtx1_X(vtx1_X), .vtx1_Y(vtx1_Y), .vtx1_Z(vtx1_Z),
        .vtx2_X(vtx2_X), .vtx2_Y(vtx2_Y), .vtx2_Z(vtx2_Z),
        .vtx3_X(vtx3_X), .vtx3_Y(vtx3_Y), .vtx3_Z(vtx3_Z),
        .vtx4_X(vtx4_X), .vtx4_Y(vtx4_Y), .vtx4_Z(vtx4_Z),
        .angleX(angleX), .angleY(angleY), .angleZ(angleZ)
    );

    always #5 clk = ~clk;

    logic [15:0] dut_out [0:17];
    always_comb begin
        dut_out[0]  = Xc;     dut_out[1]  = Yc;     dut_out[2]  = Zc;
        dut_out[3]  = vtx1_X; dut_out[4]  = vtx1_Y; dut_out[5]  = vtx1_Z;
        dut_out[6]  = vtx2_X; dut_out[7]  = vtx2_Y; dut_out[8]  = vtx2_Z;
        dut_out[9]  = vtx3_X; dut_out[10] = vtx3_Y; dut_out[11] = vtx3_Z;
        dut_out[12] = vtx4_X; dut_out[13] = vtx4_Y; dut_out[14] = vtx4_Z;
        dut_out[15] = angleX; dut_out[16] = angleY; dut_out[17] = angleZ;
    end

    typedef struct {
        logic [15:0] rd;
        logic        err;
        logic        cd;
    } exp_t;

    exp_t        sb [$];
    exp_t        e;
    logic [15:0] m_sh  [0:17];
    logic [15:0] m_act [0:17];
    int          errors = 0;
    int          checks = 0;

    function automatic logic [15:0] rst_val(input int i);
        logic [15:0] t [0:17];
        t = '{16'h0000, 16'h0000, 16'h0640, 16'h0000, 16'hff3c, 16'h0000,
              16'hff60, 16'h0041, 16'h005c, 16'h00a0, 16'h0041, 16'h005c,
              16'h0000, 16'h0041, 16'hff47, 16'h0000, 16'h0000, 16'h0000};
        return t[i];
    endfunction

    function automatic logic [15:0] wrap_add(input logic [15:0] a, input logic [15:0] s);
        int v;
        v = int'($signed(a)) + int'($signed(s));
        if (v >= 25736) v = v - 51472;
        else if (v < -25736) v = v + 51472;
        return v[15:0];
    endfunction

    function automatic logic [15:0] step_of(input int a);
        if (a == 0) return 16'h0024;
        if (a == 1) return 16'h0012;
        return 16'h0000;
    endfunction

    // Drive one cycle, advance the reference model, queue expected registered outputs.
    task automatic step(input logic r, input logic we, input logic [4:0] wa,
                        input logic [15:0] wd, input logic fs, input logic [4:0] ra);
        exp_t        x;
        logic [15:0] nsh  [0:17];
        logic [15:0] nact [0:17];
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd; frame_start = fs; rd_addr = ra;
        nsh  = m_sh;
        nact = m_act;
        if (r) begin
            for (int i = 0; i < 18; i++) begin
                nsh[i]  = rst_val(i);
                nact[i] = rst_val(i);
            end
            x.rd = 16'h0000; x.err = 1'b0; x.cd = 1'b0;
        end else begin
            if (fs) begin
                nact = m_sh;
`ifdef OBJ_AUTO_ROTATE_EN
                for (int a = 0; a < 3; a++) begin
                    nact[15+a] = wrap_add(m_sh[15+a], step_of(a));
                    nsh[15+a]  = nact[15+a];
                end
`endif
            end
            if (we && wa < 18) nsh[wa] = wd;
            x.rd  = (ra < 18) ? nsh[ra] : 16'h0000;
            x.err = we && (wa >= 18);
            x.cd  = fs;
        end
        m_sh  = nsh;
        m_act = nact;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] ra);
        step(1'b0, 1'b0, 5'd0, 16'h0000, 1'b0, ra);
    endtask

    task automatic test_reset;
        step(1'b1, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd2); e = sb.pop_front();
        step(1'b1, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd2); e = sb.pop_front();
        checks++;
        if (rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rd: got %h want 0000", rd_data); end
        for (int i = 0; i < 18; i++) begin
            checks++;
            if (dut_out[i] !== rst_val(i)) begin
                errors++; $display("FAIL reset_out[%0d]: got %h want %h", i, dut_out[i], rst_val(i));
            end
        end
        idle(5'd2); e = sb.pop_front();
        checks++;
        if (rd_data !== 16'h0640) begin errors++; $display("FAIL reset_rd2: got %h want 0640", rd_data); end
        checks++;
        if (wr_err !== 1'b0 || commit_done !== 1'b0) begin
            errors++; $display("FAIL reset_pulses: wr_err=%b commit_done=%b want 0 0", wr_err, commit_done);
        end
    endtask

    task automatic test_staged_write;
        step(1'b0, 1'b1, 5'd2, 16'h0800, 1'b0, 5'd2); e = sb.pop_front();
        checks++;
        if (rd_data !== e.rd) begin errors++; $display("FAIL staged_rd: got %h want %h", rd_data, e.rd); end
        checks++;
        if (Zc !== 16'h0640) begin errors++; $display("FAIL staged_hold: Zc got %h want 0640", Zc); end
        step(1'b0, 1'b0, 5'd0, 16'h0000, 1'b1, 5'd2); e = sb.pop_front();
        checks++;
        if (Zc !== 16'h0800) begin errors++; $display("FAIL staged_commit: Zc got %h want 0800", Zc); end
        checks++;
        if (commit_done !== e.cd) begin errors++; $display("FAIL staged_cd: got %b want %b", commit_done, e.cd); end
        idle(5'd2); e = sb.pop_front();
        checks++;
        if (commit_done !== 1'b0) begin errors++; $display("FAIL staged_cd_pulse: got %b want 0", commit_done); end
    endtask

    task automatic test_invalid;
        step(1'b0, 1'b1, 5'd20, 16'h1234, 1'b0, 5'd20); e = sb.pop_front();
        checks++;
        if (wr_err !== 1'b1) begin errors++; $display("FAIL invalid_err: got %b want 1", wr_err); end
        checks++;
        if (rd_data !== 16'h0000) begin errors++; $display("FAIL invalid_rd: got %h want 0000", rd_data); end
        for (int i = 0; i < 18; i++) begin
            idle(5'(i)); e = sb.pop_front();
            checks++;
            if (rd_data !== e.rd || wr_err !== 1'b0) begin
                errors++; $display("FAIL invalid_shadow[%0d]: rd=%h err=%b want %h 0", i, rd_data, wr_err, e.rd);
            end
            checks++;
            if (dut_out[i] !== m_act[i]) begin
                errors++; $display("FAIL invalid_out[%0d]: got %h want %h", i, dut_out[i], m_act[i]);
            end
        end
    endtask

    task automatic test_collision;
        step(1'b0, 1'b1, 5'd0, 16'h0010, 1'b0, 5'd0); e = sb.pop_front();
        step(1'b0, 1'b1, 5'd0, 16'h0020, 1'b1, 5'd0); e = sb.pop_front();
        checks++;
        if (Xc !== 16'h0010) begin errors++; $display("FAIL collision_active: Xc got %h want 0010", Xc); end
        checks++;
        if (rd_data !== 16'h0020) begin errors++; $display("FAIL collision_shadow: got %h want 0020", rd_data); end
        step(1'b0, 1'b0, 5'd0, 16'h0000, 1'b1, 5'd0); e = sb.pop_front();
        checks++;
        if (Xc !== 16'h0020) begin errors++; $display("FAIL collision_next: Xc got %h want 0020", Xc); end
    endtask

    task automatic test_back_to_back;
        for (int n = 0; n < 24; n++) begin
            step(1'b0, 1'b1, 5'($urandom_range(0, 17)), 16'($urandom), 1'b0, 5'($urandom_range(0, 19)));
            e = sb.pop_front();
            checks++;
            if (rd_data !== e.rd) begin errors++; $display("FAIL b2b_rd[%0d]: got %h want %h", n, rd_data, e.rd); end
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 5'd0, 16'h0000, 1'b1, 5'd15); e = sb.pop_front();
            checks++;
            if (commit_done !== 1'b1) begin errors++; $display("FAIL b2b_cd[%0d]: got %b want 1", k, commit_done); end
            for (int i = 0; i < 18; i++) begin
                checks++;
                if (dut_out[i] !== m_act[i]) begin
                    errors++; $display("FAIL b2b_out[%0d][%0d]: got %h want %h", k, i, dut_out[i], m_act[i]);
                end
            end
            checks++;
            if (rd_data !== e.rd) begin errors++; $display("FAIL b2b_angle_rd[%0d]: got %h want %h", k, rd_data, e.rd); end
        end
    endtask

    task automatic test_rotate;
        step(1'b1, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0); e = sb.pop_front();
        step(1'b0, 1'b1, 5'd15, 16'h6480, 1'b0, 5'd0); e = sb.pop_front();
        step(1'b0, 1'b0, 5'd0, 16'h0000, 1'b1, 5'd15); e = sb.pop_front();
`ifdef OBJ_AUTO_ROTATE_EN
        checks++;
        if (angleX !== 16'h9b94) begin errors++; $display("FAIL rotate_wrap: angleX got %h want 9b94", angleX); end
        checks++;
        if (rd_data !== 16'h9b94) begin errors++; $display("FAIL rotate_shadow: got %h want 9b94", rd_data); end
        step(1'b1, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0); e = sb.pop_front();
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 5'd0, 16'h0000, 1'b1, 5'd0); e = sb.pop_front();
        end
        checks++;
        if (angleX !== 16'h006c || angleY !== 16'h0036 || angleZ !== 16'h0000) begin
            errors++; $display("FAIL rotate_three: got %h %h %h want 006c 0036 0000", angleX, angleY, angleZ);
        end
`else
        checks++;
        if (angleX !== 16'h6480) begin errors++; $display("FAIL rotate_plain: angleX got %h want 6480", angleX); end
        checks++;
        if (angleY !== 16'h0000) begin errors++; $display("FAIL rotate_plain_y: angleY got %h want 0000", angleY); end
`endif
    endtask

    task automatic test_reset_mid_burst;
        for (int i = 3; i <= 8; i++) begin
            step(1'b0, 1'b1, 5'(i), 16'h1100 + 16'(i), 1'b0, 5'd0); e = sb.pop_front();
        end
        step(1'b0, 1'b0, 5'd0, 16'h0000, 1'b1, 5'd0); e = sb.pop_front();
        step(1'b0, 1'b1, 5'd3, 16'h2203, 1'b1, 5'd0); e = sb.pop_front();
        step(1'b1, 1'b1, 5'd4, 16'h2204, 1'b0, 5'd0); e = sb.pop_front();
        checks++;
        if (commit_done !== 1'b0) begin errors++; $display("FAIL midrst_cd: got %b want 0", commit_done); end
        for (int i = 3; i <= 8; i++) begin
            checks++;
            if (dut_out[i] !== rst_val(i)) begin
                errors++; $display("FAIL midrst_out[%0d]: got %h want %h", i, dut_out[i], rst_val(i));
            end
        end
        for (int i = 3; i <= 8; i++) begin
            idle(5'(i)); e = sb.pop_front();
            checks++;
            if (rd_data !== rst_val(i) || commit_done !== 1'b0) begin
                errors++; $display("FAIL midrst_shadow[%0d]: rd=%h cd=%b want %h 0", i, rd_data, commit_done, rst_val(i));
            end
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; frame_start = 1'b0; rd_addr = '0;
        for (int i = 0; i < 18; i++) begin
            m_sh[i]  = rst_val(i);
            m_act[i] = rst_val(i);
        end
        test_reset;
        test_staged_write;
        test_invalid;
        test_collision;
        test_back_to_back;
        test_rotate;
        test_reset_mid_burst;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
